// File: rtl/seg7_scan_reader_if.sv
// Frame output handshake between seg7_scan_reader and its consumer.
//   out_data  : decoded frame, nibble k = digit k
//   out_bad   : bit k set = digit k pattern was undecodable
//   out_valid : frame available (held until accepted)
//   out_ready : consumer accepts the frame
// master = producer (reader), slave = consumer.
interface seg7_scan_reader_if;
  logic [15:0] out_data;
  logic [3:0]  out_bad;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_bad, output out_valid, input out_ready);
  modport slave  (input out_data, input out_bad, input out_valid, output out_ready);
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 4-digit 7-segment display bus back into a 16-bit frame.
// Each digit must be shown unchanged for STABLE_CNT consecutive cycles before it
// is accepted; digits must arrive in order 0,1,2,3 to form a frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   seg_n_i     : segment lines, active-low (bit0=a .. bit6=g)
//   dig_n_i     : digit selects, active-low one-hot (bit0 = digit 0)
//   seq_err_o   : one-cycle pulse on digit-order violation
//   drop_cnt_o  : frames completed while a frame was pending (saturating)
//   bus         : frame output handshake (master side)
// Build option: define SEG7_HEX_EN to also decode the hex letters A..F.
module seg7_scan_reader #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_n_i,
  input  logic [3:0] dig_n_i,
  output logic       seq_err_o,
  output logic [7:0] drop_cnt_o,
  seg7_scan_reader_if.master bus
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);
  localparam logic [7:0] STABLE_PRE = 8'(STABLE_CNT - 1);

  typedef enum logic [1:0] {SYNC, COLLECT, PRESENT} state_t;

  state_t      state_q, state_d, shadow_q, shadow_d, trk, trk_nxt;
  logic [10:0] smp_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  exp_q, exp_d;
  logic [15:0] buf_data_q, buf_data_d, out_data_q, out_data_d;
  logic [3:0]  buf_bad_q, buf_bad_d, out_bad_q, out_bad_d;
  logic [7:0]  drop_q, drop_d;
  logic        seq_err_q, seq_err_d;

  logic [3:0]  sel;
  logic        qual, same, acc, handshake, store, complete;
  logic [1:0]  dig;
  logic [3:0]  nib;
  logic        bad;

  // Map lit-segment pattern (bit0=a) to a value; unknown patterns give F + bad.
  always_comb begin
    nib = 4'hF;
    bad = 1'b0;
    unique case (~seg_n_i)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
`ifdef SEG7_HEX_EN
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
`endif
      default: begin
        nib = 4'hF;
        bad = 1'b1;
      end
    endcase
  end

  // Sample qualification and stability counting.
  always_comb begin
    sel  = ~dig_n_i;
    qual = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    same = ({dig_n_i, seg_n_i} == smp_q);
    if (!qual)
      cnt_d = '0;
    else if (same && cnt_q != 8'd0)
      cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
    else
      cnt_d = 8'd1;
    // The counter parks at STABLE_CNT, so only the step into it accepts.
    acc = qual && same && (cnt_q == STABLE_PRE);
    unique case (sel)
      4'b0010: dig = 2'd1;
      4'b0100: dig = 2'd2;
      4'b1000: dig = 2'd3;
      default: dig = 2'd0;
    endcase
  end

  // Frame FSM. While PRESENT, the same collect rules run on shadow_q and a
  // completed shadow frame only bumps the drop counter.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    exp_d      = exp_q;
    buf_data_d = buf_data_q;
    buf_bad_d  = buf_bad_q;
    out_data_d = out_data_q;
    out_bad_d  = out_bad_q;
    drop_d     = drop_q;
    seq_err_d  = 1'b0;
    store      = 1'b0;
    complete   = 1'b0;

    handshake = (state_q == PRESENT) && bus.out_ready;
    trk       = (state_q == PRESENT) ? shadow_q : state_q;
    trk_nxt   = trk;

    if (acc && !handshake) begin
      if (trk == SYNC) begin
        if (dig == 2'd0) begin
          store   = 1'b1;
          exp_d   = 2'd1;
          trk_nxt = COLLECT;
        end
      end else if (dig == exp_q) begin
        store = 1'b1;
        if (dig == 2'd3) begin
          complete = 1'b1;
          trk_nxt  = SYNC;
        end else begin
          exp_d = exp_q + 2'd1;
        end
      end else if (dig != exp_q - 2'd1) begin
        seq_err_d = 1'b1;
        if (dig == 2'd0) begin
          store   = 1'b1;
          exp_d   = 2'd1;
          trk_nxt = COLLECT;
        end else begin
          trk_nxt = SYNC;
        end
      end
    end

    if (store) begin
      buf_data_d[{dig, 2'b00} +: 4] = nib;
      buf_bad_d[dig]                = bad;
    end

    if (handshake) begin
      state_d  = SYNC;
      shadow_d = SYNC;
    end else if (state_q == PRESENT) begin
      shadow_d = trk_nxt;
      if (complete && drop_q != 8'hFF)
        drop_d = drop_q + 8'd1;
    end else if (complete) begin
      state_d    = PRESENT;
      shadow_d   = SYNC;
      out_data_d = buf_data_d;
      out_bad_d  = buf_bad_d;
    end else begin
      state_d = trk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      shadow_q   <= SYNC;
      smp_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      buf_data_q <= '0;
      buf_bad_q  <= '0;
      out_data_q <= '0;
      out_bad_q  <= '0;
      drop_q     <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      smp_q      <= {dig_n_i, seg_n_i};
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      buf_data_q <= buf_data_d;
      buf_bad_q  <= buf_bad_d;
      out_data_q <= out_data_d;
      out_bad_q  <= out_bad_d;
      drop_q     <= drop_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_bad   = out_bad_q;
  assign bus.out_valid = (state_q == PRESENT);
  assign seq_err_o     = seq_err_q;
  assign drop_cnt_o    = drop_q;

endmodule
